// File: rtl/mem_fill_responder_pkg.sv
// Shared memory-protocol constants for the fill controllers and the memory responder.
package mem_fill_responder_pkg;

  localparam int unsigned MEM_LATENCY = 4;
  localparam int unsigned WORD_W      = 16;
  localparam int unsigned LINE_WORDS  = 8;
  localparam int unsigned MEM_ADDR_W  = 16;

  typedef enum logic {
    REQ_READ  = 1'b0,
    REQ_WRITE = 1'b1
  } req_kind_e;

endpackage : mem_fill_responder_pkg

// File: rtl/mem_resp_pipe.sv
// Fixed-depth valid+data shift chain carrying read words from capture to return.
module mem_resp_pipe #(
  parameter int unsigned LATENCY = 4,
  parameter int unsigned DATA_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data
);

  logic [LATENCY-1:0] valid_q;
  logic [DATA_W-1:0]  data_q [LATENCY];

  // Data is zeroed for empty slots so the last stage reads 0 whenever it is not valid.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
      for (int unsigned i = 0; i < LATENCY; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      valid_q[0] <= in_valid;
      data_q[0]  <= in_valid ? in_data : '0;
      for (int unsigned i = 1; i < LATENCY; i++) begin
        valid_q[i] <= valid_q[i-1];
        data_q[i]  <= data_q[i-1];
      end
    end
  end

  assign out_valid = valid_q[LATENCY-1];
  assign out_data  = data_q[LATENCY-1];

endmodule : mem_resp_pipe

// File: rtl/mem_fill_responder.sv
// Main-memory responder: fixed-latency, fully pipelined word memory for cache fills.
module mem_fill_responder
  import mem_fill_responder_pkg::*;
#(
  parameter int unsigned ADDR_W  = MEM_ADDR_W,
  parameter int unsigned DATA_W  = WORD_W,
  parameter int unsigned LATENCY = MEM_LATENCY
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              wr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic [3:0]        rd_inflight
);

  localparam int unsigned DEPTH = 2 ** (ADDR_W - 1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-2:0] word_idx_c;
  req_kind_e         kind_c;
  logic              rd_accept_c;
  logic              wr_accept_c;
  logic              unused_addr_lsb_c;

  assign word_idx_c        = addr[ADDR_W-1:1];
  assign unused_addr_lsb_c = addr[0];
  assign kind_c            = req_kind_e'(wr);
  assign rd_accept_c       = enable && (kind_c == REQ_READ);
  assign wr_accept_c       = enable && (kind_c == REQ_WRITE);

  // Contents survive reset; only the response path is cleared.
  always_ff @(posedge clk) begin
    if (wr_accept_c) begin
      mem[word_idx_c] <= data_in;
    end
  end

  // Word is snapshotted at acceptance, so later writes cannot disturb an in-flight read.
  mem_resp_pipe #(
    .LATENCY (LATENCY),
    .DATA_W  (DATA_W)
  ) u_pipe (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (rd_accept_c),
    .in_data   (mem[word_idx_c]),
    .out_valid (data_valid),
    .out_data  (data_out)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_inflight <= '0;
    end else begin
      case ({rd_accept_c, data_valid})
        2'b10:   rd_inflight <= rd_inflight + 4'd1;
        2'b01:   rd_inflight <= rd_inflight - 4'd1;
        default: rd_inflight <= rd_inflight;
      endcase
    end
  end

endmodule : mem_fill_responder
